// File: rtl/register_file_ba_pkg.sv
// Default geometry for the register file and its storage cells.
package register_file_ba_pkg;
  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 16;
endpackage

// File: rtl/register_file_ba_register_nbit.sv
// One WIDTH-bit storage register with synchronous clear and load enable.
module register_nbit
  import register_file_ba_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (clear)       q <= '0;
    else if (enable) q <= d;
  end

endmodule

// File: rtl/register_file_ba.sv
// Register file with per-register pending scoreboard, write-first bypass,
// base-address masking of register 0 and a registered 1-cycle read port.
module register_file_ba
  import register_file_ba_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  BusMuxOut,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              BAout,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              stall,
  output logic [DEPTH-1:0]  pending
);

  // Address space is padded to a power of two; unbacked slots read as zero.
  localparam int unsigned SLOTS = 2 ** ADDR_W;

  logic [WIDTH-1:0] slot [SLOTS];
  logic [SLOTS-1:0] pend_pad;
  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] lock_dec;
  logic             rd_in;
  logic             bypass;
  logic             accept;
  logic [WIDTH-1:0] rd_next;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < DEPTH) begin : g_reg
      assign wr_dec[g]   = wr_en   && (wr_addr   == ADDR_W'(g));
      assign lock_dec[g] = lock_en && (lock_addr == ADDR_W'(g));
      register_nbit #(.WIDTH(WIDTH)) u_reg (
        .clock  (clock),
        .clear  (clear),
        .enable (wr_dec[g]),
        .d      (BusMuxOut),
        .q      (slot[g])
      );
    end else begin : g_hole
      assign slot[g] = '0;
    end
  end

  assign pend_pad = SLOTS'(pending);

  always_comb begin
    rd_in  = (32'(rd_addr) < DEPTH);
    bypass = wr_en && (wr_addr == rd_addr) && rd_in;
    stall  = rd_en && !clear && pend_pad[rd_addr] && !bypass;
    accept = rd_en && !stall;
    rd_next = '0;
    if (!rd_in || (rd_addr == '0 && BAout)) rd_next = '0;
    else if (bypass)                        rd_next = BusMuxOut;
    else                                    rd_next = slot[rd_addr];
  end

  // Lock is OR-ed in after the write clear, so a same-cycle lock wins.
  always_ff @(posedge clock) begin
    if (clear) pending <= '0;
    else       pending <= (pending & ~wr_dec) | lock_dec;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept;
      if (accept) rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_register_file_ba.sv
// Randomised plus directed bench for register_file_ba (DEPTH=12) with a
// queue scoreboard fed by a behavioural model of the register file.
module tb_register_file_ba;

  localparam int unsigned W = 32;
  localparam int unsigned D = 12;
  localparam int unsigned A = 4;

  logic         clock;
  logic         clear;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] BusMuxOut;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic         BAout;
  logic         lock_en;
  logic [A-1:0] lock_addr;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         stall;
  logic [D-1:0] pending;

  register_file_ba #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .clear     (clear),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .BusMuxOut (BusMuxOut),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .BAout     (BAout),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .stall     (stall),
    .pending   (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: plain array of values and a set of locked indices.
  logic [W-1:0] mem [D];
  bit   [D-1:0] mpend;
  logic [W-1:0] expq [$];
  logic [W-1:0] exp_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_stall(bit clr, bit we, int wa, bit re, int ra);
    if (!re || clr || ra >= int'(D)) return 1'b0;
    return mpend[ra] && !(we && wa == ra);
  endfunction

  task automatic cyc(input bit clr, input bit we, input int wa, input logic [W-1:0] d,
                     input bit re, input int ra, input bit ba, input bit le, input int la);
    bit           st;
    logic [W-1:0] v;
    @(negedge clock);
    clear = clr; wr_en = we; wr_addr = A'(wa); BusMuxOut = d;
    rd_en = re; rd_addr = A'(ra); BAout = ba; lock_en = le; lock_addr = A'(la);
    #1;
    st = model_stall(clr, we, wa, re, ra);
    chk("stall", 64'(stall), 64'(st));
    @(posedge clock);
    if (clr) begin
      for (int i = 0; i < int'(D); i++) mem[i] = '0;
      mpend = '0;
      expq.delete();
      exp_last = '0;
    end else begin
      if (re && !st) begin
        if (ra >= int'(D) || (ra == 0 && ba)) v = '0;
        else if (we && wa == ra)              v = d;
        else                                  v = mem[ra];
        expq.push_back(v);
      end
      if (we && wa < int'(D)) begin
        mem[wa] = d;
        mpend[wa] = 1'b0;
      end
      if (le && la < int'(D)) mpend[la] = 1'b1;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle either the next expected read appears or the bus holds.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rd_valid", 64'(rd_valid), 64'd1);
        chk("rd_data", 64'(rd_data), 64'(e));
        exp_last = e;
      end else begin
        chk("rd_valid_idle", 64'(rd_valid), 64'd0);
        chk("rd_data_hold", 64'(rd_data), 64'(exp_last));
      end
      chk("pending", 64'(pending), 64'(mpend));
    end
  end

  initial begin
    clear = 1'b1; wr_en = 0; wr_addr = '0; BusMuxOut = '0; rd_en = 0;
    rd_addr = '0; BAout = 0; lock_en = 0; lock_addr = '0;
    for (int i = 0; i < int'(D); i++) mem[i] = '0;
    mpend = '0;
    exp_last = '0;

    cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 1, 0, 0, 0, 0);
    idle();

    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 5, 0, 0, 0);
    idle();

    cyc(0, 1, 0, 32'h00001234, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h0000BEEF, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, '0, 1, 5, 1, 0, 0);

    cyc(0, 0, 0, '0, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, '0, 1, 3, 0, 0, 0);
    cyc(0, 1, 3, 32'h00000055, 1, 3, 0, 0, 0);
    idle();

    cyc(0, 1, 7, 32'h000000A5, 0, 0, 0, 1, 7);
    cyc(0, 0, 0, '0, 1, 7, 0, 0, 0);
    idle();

    for (int i = 0; i < int'(D); i++) cyc(0, 1, i, 32'h1000 + 32'(i), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 4, 0, 1, 2);
    cyc(1, 1, 1, 32'h77777777, 1, 6, 0, 1, 5);
    cyc(0, 0, 0, '0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 2, 0, 0, 0);

    for (int i = 0; i < int'(D); i++) cyc(0, 1, i, 32'hA000 + 32'(i), 0, 0, 0, 0, 0);
    cyc(0, 1, 13, 32'h000000FF, 0, 0, 0, 1, 14);
    cyc(0, 0, 0, '0, 1, 13, 0, 0, 0);
    cyc(0, 1, 13, 32'h000000FF, 1, 13, 0, 0, 0);
    for (int i = 0; i < int'(D); i++) cyc(0, 0, 0, '0, 1, i, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(99, 0) < 3,
          $urandom_range(99, 0) < 40, int'($urandom_range(15, 0)), $urandom(),
          $urandom_range(99, 0) < 50, int'($urandom_range(15, 0)),
          $urandom_range(99, 0) < 30,
          $urandom_range(99, 0) < 20, int'($urandom_range(15, 0)));
    end

    repeat (3) idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file_ba.md
REGISTER_FILE_BA -- requirements
Module: register_file_ba

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register and bus port.
REQ-002 SHALL have parameter DEPTH, default 16, number of registers (2..64).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), register address width.
REQ-004 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port clear, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wr_en, input, 1, write strobe.
REQ-007 SHALL have port wr_addr, input, ADDR_W, write register index.
REQ-008 SHALL have port BusMuxOut, input, WIDTH, write data from bus.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port rd_addr, input, ADDR_W, read register index.
REQ-011 SHALL have port BAout, input, 1, base-address read mode; forces register 0 to read as zero.
REQ-012 SHALL have port lock_en, input, 1, mark a register pending (result outstanding).
REQ-013 SHALL have port lock_addr, input, ADDR_W, register to lock.
REQ-014 SHALL have port rd_data, output, WIDTH, registered read data to bus.
REQ-015 SHALL have port rd_valid, output, 1, one-cycle pulse: rd_data updated this cycle.
REQ-016 SHALL have port stall, output, 1, combinational: current read request refused.
REQ-017 SHALL have port pending, output, DEPTH, per-register lock flags (bit i = register i).

Function
REQ-018 Write: wr_en=1 at edge SHALL load BusMuxOut into reg[wr_addr] and clear pending[wr_addr].
REQ-019 Lock: lock_en=1 at edge SHALL set pending[lock_addr]; lock and write to same index same cycle SHALL leave data written and pending=1 (lock wins).
REQ-020 Read accept: rd_en=1 with pending[rd_addr]=0, or with wr_en=1 and wr_addr=rd_addr, SHALL be accepted; stall=0.
REQ-021 Read refuse: rd_en=1 with pending[rd_addr]=1 and no same-cycle write to rd_addr SHALL assert stall=1; no rd_valid next cycle.
REQ-022 Latency: accepted read SHALL give rd_valid=1 and rd_data the following cycle (1-cycle latency).
REQ-023 Bypass: accepted read with same-cycle write to rd_addr SHALL return BusMuxOut (write-first).
REQ-024 BA masking: accepted read with rd_addr=0 and BAout=1 SHALL return all-zero, regardless of stored value or bypass; stored reg[0] unchanged.
REQ-025 BAout with rd_addr!=0 SHALL have no effect.
REQ-026 rd_data SHALL hold its last value when no read accepted; rd_valid=0.
REQ-027 stall SHALL be 0 whenever rd_en=0.
REQ-028 Index >= DEPTH: writes and locks SHALL be ignored; reads SHALL be accepted and return zero.
REQ-029 pending SHALL reflect registered flags (post-edge state), not same-cycle requests.

Reset
REQ-030 clear=1 at edge SHALL zero all registers, pending, rd_data and rd_valid.
REQ-031 clear SHALL dominate same-cycle wr_en, lock_en and rd_en; a read accepted the cycle before clear SHALL not produce rd_valid after clear.
REQ-032 stall SHALL be 0 during the cycle clear is asserted.

Structure
REQ-033 Shared package SHALL hold default WIDTH/DEPTH constants only; no typedefs required.
REQ-034 Storage SHALL use one sub-module register_nbit (WIDTH-parametrised, clear/clock/enable) instantiated DEPTH times via generate; scoreboard and read path inline.

Verification
REQ-035 Write reg5=0xDEADBEEF, next cycle read 5 -> one cycle later rd_valid=1, rd_data=0xDEADBEEF.
REQ-036 Write reg0=0x00001234; read 0 with BAout=1 -> rd_data=0x00000000; read 0 with BAout=0 -> 0x00001234.
REQ-037 Lock reg3, read 3 -> stall=1, no rd_valid; then write reg3=0x55 with rd_en on 3 same cycle -> stall=0, next cycle rd_data=0x55, pending[3]=0.
REQ-038 Same cycle lock_en and wr_en on reg7 with 0xA5 -> reg7=0xA5, pending[7]=1; read 7 stalls.
REQ-039 Fill regs, lock reg2, assert clear with wr_en on reg1 -> all regs 0, pending=0, rd_valid=0, reg1 reads 0.
REQ-040 DEPTH=12: write index 13 with 0xFF -> no register changes; read 13 -> rd_valid=1, rd_data=0.
